// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: memory request, issue handshake, next-PC selection
//
// Ports:
//   clk, rst            - single clock; asynchronous active-high reset
//   imem_req/imem_addr  - read request to instruction memory, address is the current PC
//   imem_ack/imem_rdata - read response; data sampled only while a request is outstanding
//   inst_out/opcode     - held instruction and its opcode field for decode
//   inst_valid          - inst_out is offered to decode
//   inst_ready          - decode accepts inst_out this cycle
//   Branch/Jump/Zero    - control flow flags belonging to the instruction being accepted
//   pc                  - address of inst_out
//   illegal_op          - sticky flag: an unsupported opcode was fetched (unit halts)
//   instr_count         - number of accepted instructions
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [5:0]  opcode,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] pc,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_REQ,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        capture;
    logic        accept;
    logic        rdata_legal;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] pc_next;

    // Opcode legality is judged on the incoming word so the halt decision
    // can be made in the same cycle the word is captured.
    always_comb begin
        rdata_legal = 1'b0;
        case (imem_rdata[31:26])
            6'b000000, 6'b001101, 6'b010000, 6'b010001,
            6'b101010, 6'b010011, 6'b011100: rdata_legal = 1'b1;
            default:                         rdata_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            S_REQ: begin
                // Reset forces S_REQ asynchronously; gating with rst keeps the
                // request low for the whole time reset is held.
                imem_req = ~rst;
                if (imem_ack) begin
                    capture    = 1'b1;
                    state_next = rdata_legal ? S_ISSUE : S_HALT;
                end
            end
            S_ISSUE: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    accept     = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // Branch offset is word-granular: sign-extended imm16 shifted left by two.
    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{inst_out[15]}}, inst_out[15:0], 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        if (Jump) begin
            pc_next = {pc_plus4[31:28], inst_out[25:0], 2'b00};
        end else if (Branch && Zero) begin
            pc_next = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inst_out    <= 32'd0;
            illegal_op  <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            if (capture) begin
                inst_out <= imem_rdata;
                if (!rdata_legal) begin
                    illegal_op <= 1'b1;
                end
            end
            if (accept) begin
                pc          <= pc_next;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    assign imem_addr = pc;
    assign opcode    = inst_out[31:26];

endmodule
